eth_hdr_prepend: RTL and testbench
==================================

// Module: eth_hdr_prepend
// PURPOSE
//  Prepends a 14-byte Ethernet header (dest MAC bytes 0-5, src MAC 6-11, EtherType 12-13, byte 0 in bits [7:0])
//  to an AXI-Stream IP packet. Sits directly downstream of the Ethernet header constructor.
//  Shifts payload by 14 bytes across beats, fixes tkeep/tlast, adds 14 to the tuser length field.
// PARAMETERS
//  C_DATA_WIDTH   256  tdata width in bits; multiple of 8, >=128 (W = C_DATA_WIDTH/8 bytes)
//  C_TUSER_WIDTH  128  tuser width; [15:0] = packet length in bytes
// PORTS
//  axis_aclk      in   1        clock
//  axis_resetn    in   1        asynchronous active-low reset
//  eth_hdr        in   112      header from constructor; sampled when hdr_valid & hdr_ready
//  hdr_valid      in   1        header available for the next packet
//  hdr_ready      out  1        single-cycle pulse: header consumed
//  s_axis_tdata   in   C_DATA_WIDTH     payload (IP packet) data
//  s_axis_tkeep   in   C_DATA_WIDTH/8   byte enables; contiguous from bit 0; all ones unless tlast
//  s_axis_tuser   in   C_TUSER_WIDTH    metadata; valid on first beat
//  s_axis_tvalid  in   1
//  s_axis_tready  out  1
//  s_axis_tlast   in   1
//  m_axis_tdata   out  C_DATA_WIDTH     framed packet
//  m_axis_tkeep   out  C_DATA_WIDTH/8
//  m_axis_tuser   out  C_TUSER_WIDTH
//  m_axis_tvalid  out  1
//  m_axis_tready  in   1
//  m_axis_tlast   out  1
//  pkt_count      out  32       (ETH_HDR_PREPEND_STATS_EN only) framed packets emitted
// BEHAVIOUR
//  - Reset: all m_axis_* 0, hdr_ready 0, s_axis_tready 0, state IDLE, carry reg 0, pkt_count 0.
//    Reset mid-packet discards the packet; no partial frame resumes after reset.
//  - Output registered: one register stage, latency 1 cycle from input accept to m_axis_tvalid.
//    Output reg loads when (!m_axis_tvalid | m_axis_tready); held stable while tvalid & !tready.
//  - s_axis_tready = output reg loadable & state!=TAIL & (state!=IDLE | hdr_valid).
//  - FSM:
//    IDLE: wait hdr_valid & s_axis_tvalid & loadable. Accept beat 0: out = {in[8W-113:0], eth_hdr},
//          tuser = in tuser with [15:0] += 14 (mod 2^16), hdr_ready=1 this cycle,
//          carry <= in top 14 bytes. -> BODY, or end handling if tlast.
//    BODY: accept beat: out = {in[8W-113:0], carry}, tuser 0, carry <= in top 14 bytes.
//    End handling on accepted input beat with tlast, k = popcount(tkeep):
//      k <= W-14: out tlast=1, tkeep = (14+k) low ones -> IDLE.
//      k >  W-14: out tlast=0, tkeep all ones -> TAIL.
//    TAIL: s_axis_tready=0; out = {0, carry}, tkeep = (k-(W-14)) low ones, tlast=1 -> IDLE.
//  - Unused high tdata bytes beyond tkeep are driven 0.
//  - Header held on eth_hdr until hdr_ready; hdr_valid without payload: no action.
//  - Single-beat payload (tlast on beat 0) handled in IDLE; same k rules.
//  - Back-to-back packets: IDLE may accept next beat 0 in the cycle after the final out beat loads.
// CONFIGURATION
//  ETH_HDR_PREPEND_STATS_EN defined: pkt_count increments (wraps at 2^32) when a beat with
//   m_axis_tlast=1 transfers (tvalid & tready). Not defined: pkt_count port absent, no counter logic.
// TESTING
//  1. 64-byte payload, tkeep all ones x2, header dest=00:11:22:33:44:55 -> 3 out beats, 78 bytes,
//     last tkeep=0x3FFF, bytes 0-5 = 55 44 33 22 11 00 order per eth_hdr[47:0], tuser len 64->78.
//  2. 18-byte single beat (tkeep=0x3FFFF) -> 1 out beat, tlast, tkeep=0xFFFFFFFF.
//  3. 19-byte single beat -> beat0 tkeep all ones tlast=0, TAIL beat tkeep=0x1 tlast=1; s_axis_tready=0 in TAIL.
//  4. Random m_axis_tready 50% over 100 packets of 1..1500 bytes -> byte-exact vs model, no data change while stalled.
//  5. hdr_valid=0 with s_axis_tvalid=1 -> s_axis_tready stays 0; assert hdr_valid -> hdr_ready one pulse.
//  6. axis_resetn low mid-packet -> outputs 0 next edge; next packet framed correctly; pkt_count (EN) = 0.

Source files
------------

// File: rtl/eth_hdr_prepend.sv
// Prepends a 14-byte Ethernet header to an AXI-Stream IP packet, re-aligning payload bytes across beats.
// Optional frame counter on port pkt_count is built when ETH_HDR_PREPEND_STATS_EN is defined.
module eth_hdr_prepend #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128
) (
    input  logic                       axis_aclk,
    input  logic                       axis_resetn,
    input  logic [111:0]               eth_hdr,
    input  logic                       hdr_valid,
    output logic                       hdr_ready,
    input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
`ifdef ETH_HDR_PREPEND_STATS_EN
    ,
    output logic [31:0]                pkt_count
`endif
);

    localparam int W  = C_DATA_WIDTH / 8;
    localparam int HB = 14;
    localparam int HW = HB * 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_TAIL = 2'd2
    } state_e;

    function automatic logic [C_DATA_WIDTH-1:0] mask_bytes(
        input logic [C_DATA_WIDTH-1:0] data,
        input logic [W-1:0]            keep
    );
        logic [C_DATA_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < W; i++) begin
            res[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

    state_e                   state_q, state_d;
    logic [HW-1:0]            carry_q, carry_d;
    logic [W-1:0]             tail_keep_q, tail_keep_d;
    logic [C_DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic [W-1:0]             m_tkeep_q, m_tkeep_d;
    logic [C_TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;
    logic                     m_tvalid_q, m_tvalid_d;
    logic                     m_tlast_q, m_tlast_d;

    logic                     loadable_s;
    logic                     s_tready_s;
    logic                     accept_s;
    logic                     long_last_s;
    logic [C_DATA_WIDTH-1:0]  in_data_s;

    // Handshake decode: input is only taken when the output register can take the resulting beat
    always_comb begin
        loadable_s  = ~m_tvalid_q | m_axis_tready;
        s_tready_s  = axis_resetn & loadable_s & (state_q != ST_TAIL)
                      & ((state_q != ST_IDLE) | hdr_valid);
        accept_s    = s_tready_s & s_axis_tvalid;
        long_last_s = s_axis_tkeep[W-HB];
        in_data_s   = mask_bytes(s_axis_tdata, s_axis_tkeep);
    end

    assign s_axis_tready = s_tready_s;
    assign hdr_ready     = accept_s & (state_q == ST_IDLE);
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;

    // Next-state and output-register computation for the framing FSM
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        tail_keep_d = tail_keep_q;
        m_tdata_d   = m_tdata_q;
        m_tkeep_d   = m_tkeep_q;
        m_tuser_d   = m_tuser_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        if (loadable_s) begin
            m_tvalid_d = 1'b0;
            case (state_q)
                ST_IDLE, ST_BODY: begin
                    if (accept_s) begin
                        m_tvalid_d = 1'b1;
                        carry_d    = in_data_s[C_DATA_WIDTH-1 -: HW];
                        if (state_q == ST_IDLE) begin
                            m_tdata_d        = {in_data_s[C_DATA_WIDTH-HW-1:0], eth_hdr};
                            m_tuser_d        = s_axis_tuser;
                            m_tuser_d[15:0]  = s_axis_tuser[15:0] + 16'd14;
                        end else begin
                            m_tdata_d = {in_data_s[C_DATA_WIDTH-HW-1:0], carry_q};
                            m_tuser_d = '0;
                        end
                        // The 14 carried bytes overflow into an extra beat only if the last beat is long
                        if (s_axis_tlast && long_last_s) begin
                            m_tkeep_d   = '1;
                            m_tlast_d   = 1'b0;
                            tail_keep_d = {{(W-HB){1'b0}}, s_axis_tkeep[W-1 -: HB]};
                            state_d     = ST_TAIL;
                        end else if (s_axis_tlast) begin
                            m_tkeep_d = {s_axis_tkeep[W-HB-1:0], {HB{1'b1}}};
                            m_tlast_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            m_tkeep_d = '1;
                            m_tlast_d = 1'b0;
                            state_d   = ST_BODY;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_TAIL: begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = {{(C_DATA_WIDTH-HW){1'b0}}, carry_q};
                    m_tkeep_d  = tail_keep_q;
                    m_tuser_d  = '0;
                    m_tlast_d  = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            m_tvalid_d = m_tvalid_q;
        end
    end

    // State, carry and output register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q     <= ST_IDLE;
            carry_q     <= '0;
            tail_keep_q <= '0;
            m_tdata_q   <= '0;
            m_tkeep_q   <= '0;
            m_tuser_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            tail_keep_q <= tail_keep_d;
            m_tdata_q   <= m_tdata_d;
            m_tkeep_q   <= m_tkeep_d;
            m_tuser_q   <= m_tuser_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
        end
    end

`ifdef ETH_HDR_PREPEND_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;

    // Count frames whose final beat is handed downstream
    always_comb begin
        if (m_tvalid_q && m_axis_tready && m_tlast_q) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // Frame counter register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_count_q <= 32'd0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_eth_hdr_prepend.sv
// Directed bench for eth_hdr_prepend: expected frames are rebuilt byte by byte from header + payload.
module tb_eth_hdr_prepend;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [111:0]  eth_hdr;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [255:0]  s_tdata;
    logic [31:0]   s_tkeep;
    logic [127:0]  s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [255:0]  m_tdata;
    logic [31:0]   m_tkeep;
    logic [127:0]  m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
`ifdef ETH_HDR_PREPEND_STATS_EN
    logic [31:0]   pkt_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lens [100];

    eth_hdr_prepend #(.C_DATA_WIDTH(256), .C_TUSER_WIDTH(128)) dut (
        .axis_aclk     (clk),
        .axis_resetn   (rst_n),
        .eth_hdr       (eth_hdr),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast)
`ifdef ETH_HDR_PREPEND_STATS_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int idx, input int seed);
        return 8'((idx * 13 + seed * 7 + 1) & 255);
    endfunction

    function automatic logic [111:0] mk_hdr(input int seed);
        return {16'h0800, 16'h0A0B, 32'(seed * 3 + 5), 48'(seed * 77 + 9)};
    endfunction

    task automatic set_beat(input int len, input int seed, input int b, input logic [15:0] tlen);
        for (int i = 0; i < 32; i++) begin
            if (b * 32 + i < len) begin
                s_tdata[8*i +: 8] = pay(b * 32 + i, seed);
                s_tkeep[i]        = 1'b1;
            end else begin
                s_tdata[8*i +: 8] = 8'hEE;
                s_tkeep[i]        = 1'b0;
            end
        end
        s_tuser = (b == 0) ? {96'h0, 16'(seed), tlen} : 128'h0;
        s_tlast = (b == (len + 31) / 32 - 1);
    endtask

    task automatic drv_pkt(input int len, input int seed, input logic [15:0] tlen, input logic [111:0] hdr);
        int nb;
        nb = (len + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            logic acc;
            int   guard;
            @(negedge clk);
            eth_hdr   = hdr;
            hdr_valid = (b == 0);
            s_tvalid  = 1'b1;
            set_beat(len, seed, b, tlen);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 5000) begin
                #1;
                acc = s_tready;
                if (b > 0) chk("hdr_ready_body", hdr_ready, 1'b0);
                @(posedge clk);
                if (!acc) begin
                    guard++;
                    @(negedge clk);
                end
            end
            chk("drv_timeout", acc, 1'b1);
        end
    endtask

    task automatic drop_in();
        @(negedge clk);
        s_tvalid  = 1'b0;
        hdr_valid = 1'b0;
        s_tlast   = 1'b0;
    endtask

    task automatic rcv_pkt(input int len, input int seed, input logic [15:0] tlen, input logic [111:0] hdr,
                           input bit stall);
        int nout;
        int tot;
        tot  = len + 14;
        nout = (tot + 31) / 32;
        for (int j = 0; j < nout; j++) begin
            logic [255:0] e_data;
            logic [31:0]  e_keep;
            logic [127:0] e_user;
            logic         done;
            int           guard;
            for (int i = 0; i < 32; i++) begin
                int idx;
                idx = j * 32 + i;
                if (idx < 14) begin
                    e_data[8*i +: 8] = hdr[8*idx +: 8];
                    e_keep[i]        = 1'b1;
                end else if (idx < tot) begin
                    e_data[8*i +: 8] = pay(idx - 14, seed);
                    e_keep[i]        = 1'b1;
                end else begin
                    e_data[8*i +: 8] = 8'h00;
                    e_keep[i]        = 1'b0;
                end
            end
            e_user = (j == 0) ? {96'h0, 16'(seed), 16'(tlen + 16'd14)} : 128'h0;
            done   = 1'b0;
            guard  = 0;
            while (!done && guard < 5000) begin
                @(negedge clk);
                m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (m_tvalid) begin
                    chk("m_tdata", m_tdata, e_data);
                    chk("m_tkeep", m_tkeep, e_keep);
                    chk("m_tlast", m_tlast, (j == nout - 1));
                    chk("m_tuser", m_tuser, e_user);
                    done = m_tready;
                end
                guard++;
            end
            chk("rcv_timeout", done, 1'b1);
        end
        m_tready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; eth_hdr = '0; hdr_valid = 1'b0; s_tdata = '0; s_tkeep = '0;
        s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        #12;
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tdata", m_tdata, 256'h0);
        chk("rst_s_tready", s_tready, 1'b0);
        chk("rst_hdr_ready", hdr_ready, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // 64-byte payload, two full beats -> three output beats of 78 bytes
        fork
            begin drv_pkt(64, 1, 16'd64, {16'h0800, 48'h66778899AABB, 48'h001122334455}); drop_in(); end
            rcv_pkt(64, 1, 16'd64, {16'h0800, 48'h66778899AABB, 48'h001122334455}, 1'b0);
        join

        // 18 bytes fills exactly one output beat
        fork
            begin drv_pkt(18, 2, 16'd18, mk_hdr(2)); drop_in(); end
            rcv_pkt(18, 2, 16'd18, mk_hdr(2), 1'b0);
        join

        // 19 bytes spills one byte into a tail beat; input must be refused while in the tail
        fork
            begin
                drv_pkt(19, 3, 16'd19, mk_hdr(3));
                @(negedge clk);
                hdr_valid = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b0;
                #1;
                chk("tail_s_tready", s_tready, 1'b0);
                hdr_valid = 1'b0; s_tvalid = 1'b0;
            end
            rcv_pkt(19, 3, 16'd19, mk_hdr(3), 1'b0);
        join

        // length field wraps modulo 2^16
        fork
            begin drv_pkt(5, 4, 16'hFFF5, mk_hdr(4)); drop_in(); end
            rcv_pkt(5, 4, 16'hFFF5, mk_hdr(4), 1'b0);
        join

        // back-to-back packets with random downstream stalls
        lens[0] = 1; lens[1] = 17; lens[2] = 18; lens[3] = 19; lens[4] = 50; lens[5] = 51;
        for (int p = 6; p < 100; p++) lens[p] = $urandom_range(1, 1500);
        fork
            begin
                for (int p = 0; p < 100; p++) drv_pkt(lens[p], 10 + p, 16'(lens[p]), mk_hdr(10 + p));
                drop_in();
            end
            begin
                for (int p = 0; p < 100; p++) rcv_pkt(lens[p], 10 + p, 16'(lens[p]), mk_hdr(10 + p), 1'b1);
            end
        join

        // payload waits without a header, then header arrives and is consumed once
        fork
            begin
                @(negedge clk);
                eth_hdr = mk_hdr(5); hdr_valid = 1'b0; s_tvalid = 1'b1;
                set_beat(10, 5, 0, 16'd10);
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk("nohdr_s_tready", s_tready, 1'b0);
                    chk("nohdr_hdr_ready", hdr_ready, 1'b0);
                    @(negedge clk);
                end
                hdr_valid = 1'b1;
                #1;
                chk("hdr_ready_pulse", hdr_ready, 1'b1);
                @(posedge clk);
                @(negedge clk);
                hdr_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
                #1;
                chk("hdr_ready_after", hdr_ready, 1'b0);
            end
            rcv_pkt(10, 5, 16'd10, mk_hdr(5), 1'b0);
        join

        // reset in the middle of a packet, then a clean packet
        @(negedge clk);
        m_tready = 1'b0; eth_hdr = mk_hdr(6); hdr_valid = 1'b1; s_tvalid = 1'b1;
        set_beat(100, 6, 0, 16'd100);
        #1;
        chk("mid_accept", s_tready, 1'b1);
        @(negedge clk);
        hdr_valid = 1'b0; s_tvalid = 1'b0;
        #1;
        chk("mid_m_tvalid", m_tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_m_tvalid", m_tvalid, 1'b0);
        chk("rstmid_m_tdata", m_tdata, 256'h0);
        chk("rstmid_m_tkeep", m_tkeep, 32'h0);
        chk("rstmid_m_tlast", m_tlast, 1'b0);
`ifdef ETH_HDR_PREPEND_STATS_EN
        chk("rstmid_pkt_count", pkt_count, 32'd0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; m_tready = 1'b1;
        fork
            begin drv_pkt(40, 7, 16'd40, mk_hdr(7)); drop_in(); end
            rcv_pkt(40, 7, 16'd40, mk_hdr(7), 1'b0);
        join
        @(negedge clk);
        #1;
        chk("post_idle_tvalid", m_tvalid, 1'b0);
`ifdef ETH_HDR_PREPEND_STATS_EN
        chk("post_pkt_count", pkt_count, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
